// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Reads a contiguous word range (base, count) from the read port of a simple
// dual-port RAM and presents it as a valid/ready stream. The RAM's one-cycle
// registered read latency is hidden behind a 2-entry output buffer. This
// sustains one word per cycle while m_ready is held high, and no word is lost
// or repeated under backpressure.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   start                request pulse; only looked at while idle
//   base_addr, count     first word address and number of words to stream
//   ram_length           RAM size in words, used for the range check
//   ram_address, ram_oe  RAM read address / read strobe
//   ram_dout             RAM read data, valid the cycle after the address edge
//   m_data, m_valid      stream output (held stable while stalled)
//   m_ready              stream ready from the sink
//   busy                 high while a request is being served
//   done                 one-cycle pulse when a request completes
//   err                  range error, held until the next accepted start
module ram_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [31:0]      count,
    input  logic [31:0]      ram_length,
    output logic [31:0]      ram_address,
    output logic             ram_oe,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // The limit cannot exceed what the RAM can decode.
    localparam logic [31:0] LIMIT_RST =
        (WORDS > (1 << DEPTH)) ? 32'(1 << DEPTH) : 32'(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                  state;
    logic [31:0]             base_q;
    logic [31:0]             count_q;
    logic [31:0]             limit_q;
    logic [31:0]             issued;
    logic [31:0]             accepted;
    logic                    inflight;   // read issued last edge, data on ram_dout now
    logic [1:0]              occ;
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0][WIDTH-1:0]   fifo;

    logic                    accept_start;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    last_pop;
    logic [2:0]              pend;
    logic [32:0]             end_addr;

    assign accept_start = (state == IDLE) && start;
    assign m_valid      = (occ != 2'd0);
    assign m_data       = fifo[rd_ptr];
    assign pop          = m_valid && m_ready;
    assign push         = inflight;
    assign busy         = (state != IDLE);

    // Words buffered plus the one possibly in flight. A pop this cycle frees a
    // slot, so the test is written as pend < 2 + pop to stay unsigned.
    assign pend  = {1'b0, occ} + {2'b0, inflight};
    assign issue = (state == RUN) && (issued < count_q) &&
                   (pend < (3'd2 + {2'b0, pop}));

    assign ram_oe      = issue;
    assign ram_address = issue ? (base_q + issued) : 32'd0;

    assign last_pop = pop && (accepted == (count_q - 32'd1));
    assign end_addr = {1'b0, base_addr} + {1'b0, count};

    // Control FSM: request latch, range check, done/err flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            base_q  <= 32'd0;
            count_q <= 32'd0;
            limit_q <= LIMIT_RST;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            limit_q <= ram_length;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= count;
                        err     <= 1'b0;
                        if (count == 32'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (end_addr > {1'b0, limit_q}) begin
                            err   <= 1'b1;
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_pop) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: issue/accept counters and the 2-entry output buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued   <= 32'd0;
            accepted <= 32'd0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo     <= '0;
        end else begin
            inflight <= issue;
            if (accept_start) begin
                issued   <= 32'd0;
                accepted <= 32'd0;
            end else begin
                if (issue) issued   <= issued + 32'd1;
                if (pop)   accepted <= accepted + 32'd1;
            end
            if (push) begin
                fifo[wr_ptr] <= ram_dout;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Downstream consumer of the simple dual-port RAM's read port. Replays a contiguous word range (base, count) out of the RAM as a valid/ready stream.
- Hides the RAM's 1-cycle registered read latency behind a 2-entry output buffer.
- Tolerates arbitrary downstream backpressure without losing or duplicating words.
- Sits between the RAM and any streaming sink (serializer, DMA, arithmetic pipeline).

Parameters:
WIDTH, 32, data word width; matches the RAM WIDTH.
DEPTH, 10, number of address bits the RAM decodes.
WORDS, 1024, nominal RAM size; used only as reset value of internal limit before ram_length is sampled.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
base_addr  in  32  first word address
count  in  32  number of words to stream
ram_length  in  32  RAM length output
ram_address  out  32  RAM read address (address_b)
ram_oe  out  1  RAM read strobe (oe_b)
ram_dout  in  WIDTH  RAM read data (dout_b), valid the cycle after the address edge
m_data  out  WIDTH  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
err  out  1  range error flag, held until next accepted start

Behaviour:
- Reset (reset=0, asynchronous):
  - State -> IDLE; issue/accept counters, in-flight flag and buffer occupancy -> 0.
  - Outputs: m_valid=0, ram_oe=0, ram_address=0, busy=0, done=0, err=0, m_data=0.
  - Reset mid-transfer discards in-flight and buffered words; no done pulse is generated.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On the clock edge with start=1: latch base_addr/count, clear err.
  - count==0 -> FIN.
  - base_addr+count > ram_length (33-bit unsigned compare) -> set err, go to FIN; no RAM read is ever issued.
  - Otherwise -> RUN.
- RUN, read issue:
  - ram_oe=1, ram_address=base+issued (combinational from registers) when all hold:
    - issued < count
    - occ + inflight - pop < 2, where pop = m_valid & m_ready in the same cycle.
  - This sustains 1 word/cycle with m_ready held high, and never exceeds 2 words buffered plus pending.
- RUN, data path:
  - The cycle after an issue edge, ram_dout is pushed into the 2-entry FIFO.
  - m_data/m_valid come from the FIFO head.
  - m_data is held stable while m_valid=1 and m_ready=0.
  - Simultaneous push and pop keeps occupancy unchanged.
- RUN -> FIN on the edge where the count-th word handshakes.
- FIN: done=1 for exactly one cycle, then -> IDLE.
- busy=1 in RUN and FIN, 0 in IDLE.
- start asserted while busy is ignored: no relatch, no effect.
- Address arithmetic: 32-bit; no wrap occurs because of the range check. The RAM uses ram_address[DEPTH-1:0].
- Timing, start sampled at edge E0:
  - First ram_oe in the cycle after E0; RAM samples at E1; data pushed at E2; m_valid=1 after E2.
  - With m_ready=1, words appear on consecutive cycles.
  - done is high in the cycle after the last handshake edge.

Test Plan:
1. RAM mem[i]=i+100, start base=8 count=4, m_ready=1 -> m_data 108,109,110,111 on 4 consecutive cycles, first m_valid 2 cycles after start; done high 6 cycles after start edge; err=0.
2. Same transfer, m_ready=0 for 5 cycles after first m_valid -> at most 2 ram_oe pulses during the stall, m_data held at 108; after release, all 4 words delivered in order with no gaps or duplicates.
3. start count=0 -> done pulse in the cycle after start; no ram_oe, no m_valid; busy high for exactly that one cycle.
4. ram_length=1024, start base=1020 count=8 -> err=1, done pulse; ram_oe never asserted; err stays 1 until next accepted start.
5. start pulsed again during case 1 with base=0 -> ignored; output sequence identical to case 1.
6. reset driven low after 2 words accepted in a count=6 transfer -> all outputs 0 immediately (asynchronous); no done pulse; a fresh start afterwards streams correctly from its base.
